// File: rtl/quant_stream_if.sv
// +---------------------------------------------------------------------------+
// | quant_stream_if                                                           |
// | Coefficient-in / quantized-out stream bundle for quant_stream.            |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface quant_stream_if #(
    parameter int DATA_W = 11,
    parameter int OUT_W  = 11
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              tbl_sel;
    logic [1:0]        qshift;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic [5:0]        m_index;
    logic              m_last;

    modport slave (
        input  s_valid, s_data, tbl_sel, qshift, m_ready,
        output s_ready, m_valid, m_data, m_index, m_last
    );

    modport master (
        output s_valid, s_data, tbl_sel, qshift, m_ready,
        input  s_ready, m_valid, m_data, m_index, m_last
    );
endinterface

`default_nettype wire

// File: rtl/quant_stream.sv
// +---------------------------------------------------------------------------+
// | quant_stream                                                              |
// | Streaming 8x8 JPEG quantizer: |x| / (Q << qshift) through a pipelined     |
// | restoring divider with stall-everywhere backpressure.                     |
// | Option macro: QUANT_ROUND_EN (round half away from zero, else truncate).  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module quant_stream #(
    parameter int DATA_W = 11,
    parameter int OUT_W  = 11
) (
    input  logic           clk,
    input  logic           rst,
    quant_stream_if.slave  bus
);
    localparam int c_qw = DATA_W + 1;
    // Dividend is widened so |x| + D/2 never overflows, even for small DATA_W
    localparam int c_nw = ((DATA_W + 1 > 10) ? DATA_W + 1 : 10) + 1;

    localparam logic [6:0] c_luma [64] = '{
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
    };

    localparam logic [6:0] c_chroma [64] = '{
        7'd17, 7'd18, 7'd24, 7'd47, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd18, 7'd21, 7'd26, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd24, 7'd26, 7'd56, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd47, 7'd66, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99,
        7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99, 7'd99
    };

    localparam logic [c_qw-1:0] c_pos_lim = c_qw'((1 << (OUT_W - 1)) - 1);
    localparam logic [c_qw-1:0] c_neg_lim = c_qw'(1 << (OUT_W - 1));

    logic              w_adv;
    logic              w_acc;
    logic [5:0]        r_idx;
    logic              r_tbl;
    logic [1:0]        r_qs;

    logic              w_sel;
    logic [1:0]        w_qs;
    logic [6:0]        w_q;
    logic [9:0]        w_d;
    logic [DATA_W:0]   w_ext;
    logic [DATA_W:0]   w_abs;
    logic [c_nw-1:0]   w_num;

    // Stage 0 is the input register; stage k+1 holds the result of divide step k
    logic              r_v   [c_qw+1];
    logic [c_qw-1:0]   r_dq  [c_qw+1];
    logic              r_sg  [c_qw+1];
    logic [5:0]        r_ix  [c_qw+1];
    logic [9:0]        r_rem [c_qw];
    logic [9:0]        r_d   [c_qw];

    logic [10:0]       w_trial;
    logic [9:0]        w_nrem [c_qw];
    logic              w_qb   [c_qw];
    logic [c_qw-1:0]   w_qf;
    logic [OUT_W-1:0]  w_sat;

    logic              r_mv;
    logic [OUT_W-1:0]  r_md;
    logic [5:0]        r_mi;
    logic              r_ml;

    assign w_adv       = !r_mv || bus.m_ready;
    assign w_acc       = bus.s_valid && w_adv;
    assign bus.s_ready = w_adv;
    assign bus.m_valid = r_mv;
    assign bus.m_data  = r_md;
    assign bus.m_index = r_mi;
    assign bus.m_last  = r_ml;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 6'd0;
            r_tbl <= 1'b0;
            r_qs  <= 2'd0;
        end else if (w_acc) begin
            r_idx <= r_idx + 6'd1;
            if (r_idx == 6'd0) begin
                r_tbl <= bus.tbl_sel;
                r_qs  <= bus.qshift;
            end
        end
    end

    // The index-0 beat uses the live selects; the rest of the block uses the latch
    always_comb begin
        w_sel = (r_idx == 6'd0) ? bus.tbl_sel : r_tbl;
        w_qs  = (r_idx == 6'd0) ? bus.qshift  : r_qs;
        w_q   = w_sel ? c_chroma[r_idx] : c_luma[r_idx];
        w_d   = {3'b000, w_q} << w_qs;
        w_ext = {bus.s_data[DATA_W-1], bus.s_data};
        w_abs = w_ext[DATA_W] ? (~w_ext + 1'b1) : w_ext;
`ifdef QUANT_ROUND_EN
        w_num = c_nw'(w_abs) + c_nw'(w_d[9:1]);
`else
        w_num = c_nw'(w_abs);
`endif
    end

    // Partial remainder stays below D, so trial < 2D fits 11 bits
    always_comb begin
        w_trial = 11'd0;
        for (int k = 0; k < c_qw; k++) begin
            w_trial = {r_rem[k], r_dq[k][c_qw-1]};
            if (w_trial >= {1'b0, r_d[k]}) begin
                w_nrem[k] = w_trial[9:0] - r_d[k];
                w_qb[k]   = 1'b1;
            end else begin
                w_nrem[k] = w_trial[9:0];
                w_qb[k]   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= c_qw; k++) begin
                r_v[k]  <= 1'b0;
                r_dq[k] <= '0;
                r_sg[k] <= 1'b0;
                r_ix[k] <= 6'd0;
            end
            for (int k = 0; k < c_qw; k++) begin
                r_rem[k] <= 10'd0;
                r_d[k]   <= 10'd0;
            end
        end else if (w_adv) begin
            r_v[0]   <= bus.s_valid;
            r_dq[0]  <= w_num[c_qw-1:0];
            r_rem[0] <= 10'(w_num[c_nw-1:c_qw]);
            r_d[0]   <= w_d;
            r_sg[0]  <= bus.s_data[DATA_W-1];
            r_ix[0]  <= r_idx;
            for (int k = 0; k < c_qw; k++) begin
                r_v[k+1]  <= r_v[k];
                r_dq[k+1] <= {r_dq[k][c_qw-2:0], w_qb[k]};
                r_sg[k+1] <= r_sg[k];
                r_ix[k+1] <= r_ix[k];
            end
            for (int k = 0; k < c_qw - 1; k++) begin
                r_rem[k+1] <= w_nrem[k];
                r_d[k+1]   <= r_d[k];
            end
        end
    end

    always_comb begin
        w_qf = r_dq[c_qw];
        if (!r_sg[c_qw]) begin
            w_sat = (w_qf > c_pos_lim) ? {1'b0, {(OUT_W-1){1'b1}}} : w_qf[OUT_W-1:0];
        end else begin
            w_sat = (w_qf > c_neg_lim) ? {1'b1, {(OUT_W-1){1'b0}}}
                                       : (~w_qf[OUT_W-1:0] + 1'b1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mv <= 1'b0;
            r_md <= '0;
            r_mi <= 6'd0;
            r_ml <= 1'b0;
        end else if (w_adv) begin
            r_mv <= r_v[c_qw];
            r_md <= w_sat;
            r_mi <= r_ix[c_qw];
            r_ml <= (r_ix[c_qw] == 6'd63);
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_quant_stream.sv
// +---------------------------------------------------------------------------+
// | tb_quant_stream                                                           |
// | Directed self-checking bench for quant_stream (main and OUT_W=6 copies).  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_quant_stream;
    localparam int DATA_W = 11;
    localparam int OUT_W  = 11;
    localparam int SAT_W  = 6;
`ifdef QUANT_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    quant_stream_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();
    quant_stream_if #(.DATA_W(DATA_W), .OUT_W(SAT_W)) sbus ();

    quant_stream #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    quant_stream #(.DATA_W(DATA_W), .OUT_W(SAT_W)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    assign sbus.s_valid = bus.s_valid;
    assign sbus.s_data  = bus.s_data;
    assign sbus.tbl_sel = bus.tbl_sel;
    assign sbus.qshift  = bus.qshift;
    assign sbus.m_ready = bus.m_ready;

    int luma [64] = '{16,11,10,16,24,40,51,61, 12,12,14,19,26,58,60,55,
                      14,13,16,24,40,57,69,56, 14,17,22,29,51,87,80,62,
                      18,22,37,56,68,109,103,77, 24,35,55,64,81,104,113,92,
                      49,64,78,87,103,121,120,101, 72,92,95,98,112,100,103,99};
    int chroma [64] = '{17,18,24,47,99,99,99,99, 18,21,26,66,99,99,99,99,
                        24,26,56,99,99,99,99,99, 47,66,99,99,99,99,99,99,
                        99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99,
                        99,99,99,99,99,99,99,99, 99,99,99,99,99,99,99,99};

    typedef struct {
        int data;
        int sdata;
        int index;
        bit last;
        int cyc;
    } obs_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    obs_t obs[$];
    int   acc_cyc[$];
    int   exp_q[$];
    int   t_idx, t_qs;
    bit   t_tbl;
    int   stall_seen, stall_viol;
    bit   prev_stall;
    logic [OUT_W-1:0] p_data;
    logic [5:0]       p_index;
    logic             p_last;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int exp_val(int x, bit tbl, int qs, int ix, int ow);
        int d, a, q, r, lim;
        d = (tbl ? chroma[ix] : luma[ix]) << qs;
        a = (x < 0) ? -x : x;
        if (RND) a = a + d / 2;
        q = a / d;
        r = (x < 0) ? -q : q;
        lim = 1 << (ow - 1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    task automatic model_reset();
        t_idx = 0; t_tbl = 1'b0; t_qs = 0;
        prev_stall = 1'b0;
        obs.delete(); acc_cyc.delete(); exp_q.delete();
    endtask

    // Samples at the falling edge, then returns 1 time unit after the next rising edge
    task automatic tick();
        obs_t o;
        @(negedge clk);
        if (!rst && bus.s_valid && bus.s_ready) begin
            acc_cyc.push_back(cyc);
            if (t_idx == 0) begin
                t_tbl = bus.tbl_sel;
                t_qs  = int'(bus.qshift);
            end
            exp_q.push_back(exp_val(int'($signed(bus.s_data)), t_tbl, t_qs, t_idx, OUT_W));
            t_idx = (t_idx + 1) % 64;
        end
        if (prev_stall) begin
            stall_seen++;
            if (bus.m_valid !== 1'b1 || bus.m_data !== p_data ||
                bus.m_index !== p_index || bus.m_last !== p_last)
                stall_viol++;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        p_data = bus.m_data; p_index = bus.m_index; p_last = bus.m_last;
        if (bus.m_valid && bus.m_ready) begin
            o.data  = int'($signed(bus.m_data));
            o.sdata = int'($signed(sbus.m_data));
            o.index = int'(bus.m_index);
            o.last  = bus.m_last;
            o.cyc   = cyc;
            obs.push_back(o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic beat(int d, bit t, int qs);
        bus.s_valid = 1'b1;
        bus.s_data  = d[DATA_W-1:0];
        bus.tbl_sel = t;
        bus.qshift  = qs[1:0];
        tick();
    endtask

    task automatic drain();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        repeat (20) tick();
    endtask

    task automatic test_reset();
        #12;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b expected 0", bus.m_valid); end
        checks++; if (bus.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %0d expected 0", bus.m_data); end
        checks++; if (bus.m_index !== 6'd0) begin errors++; $display("FAIL reset_m_index: got %0d expected 0", bus.m_index); end
        checks++; if (bus.m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last: got %b expected 0", bus.m_last); end
        checks++; if (bus.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", bus.s_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        tick();
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL idle_m_valid: got %b expected 0", bus.m_valid); end
    endtask

    // Luma block with qshift 0; the first beat is sent alone to measure latency
    task automatic test_luma_block();
        int n;
        model_reset();
        beat(1000, 1'b0, 0);
        bus.s_valid = 1'b0;
        n = 0;
        while (obs.size() == 0 && n < 40) begin tick(); n++; end
        checks++;
        if (obs.size() == 0) begin
            errors++; $display("FAIL latency_timeout: got no output expected one within 40 cycles");
        end else if (obs[0].cyc - acc_cyc[0] != 14) begin
            // The accepting edge counts as the first of the 14
            errors++; $display("FAIL latency: got %0d expected 14", obs[0].cyc - acc_cyc[0]);
        end
        for (int i = 1; i < 64; i++)
            beat((i == 2) ? -1024 : (i == 5) ? 100 : 3 * i, 1'b1, 2);
        drain();
        checks++;
        if (obs.size() != 64) begin
            errors++; $display("FAIL luma_count: got %0d expected 64", obs.size());
            return;
        end
        checks++; if (obs[0].data != (RND ? 63 : 62)) begin errors++; $display("FAIL luma_idx0: got %0d expected %0d", obs[0].data, RND ? 63 : 62); end
        checks++; if (obs[0].index != 0) begin errors++; $display("FAIL luma_idx0_index: got %0d expected 0", obs[0].index); end
        checks++; if (obs[5].data != (RND ? 3 : 2)) begin errors++; $display("FAIL luma_idx5: got %0d expected %0d", obs[5].data, RND ? 3 : 2); end
        checks++; if (obs[2].data != -102) begin errors++; $display("FAIL luma_idx2_neg: got %0d expected -102", obs[2].data); end
        checks++; if (obs[2].sdata != -32) begin errors++; $display("FAIL sat_neg: got %0d expected -32", obs[2].sdata); end
        checks++; if (obs[63].last !== 1'b1 || obs[63].index != 63) begin errors++; $display("FAIL luma_last: got last=%b index=%0d expected last=1 index=63", obs[63].last, obs[63].index); end
        checks++; if (obs[62].last !== 1'b0) begin errors++; $display("FAIL luma_not_last: got %b expected 0", obs[62].last); end
    endtask

    task automatic test_negative_and_saturation();
        model_reset();
        for (int i = 0; i < 64; i++)
            beat((i == 0) ? -1000 : (i == 2) ? 1023 : 0, 1'b0, 0);
        drain();
        checks++;
        if (obs.size() != 64) begin
            errors++; $display("FAIL neg_count: got %0d expected 64", obs.size());
            return;
        end
        checks++; if (obs[0].data != (RND ? -63 : -62)) begin errors++; $display("FAIL neg_idx0: got %0d expected %0d", obs[0].data, RND ? -63 : -62); end
        checks++; if (obs[2].data != 102) begin errors++; $display("FAIL pos_idx2: got %0d expected 102", obs[2].data); end
        checks++; if (obs[2].sdata != 31) begin errors++; $display("FAIL sat_pos: got %0d expected 31", obs[2].sdata); end
        checks++; if (obs[1].data != 0) begin errors++; $display("FAIL zero_idx1: got %0d expected 0", obs[1].data); end
    endtask

    // Chroma block followed with no gap by a block whose selects change after index 0
    task automatic test_back_to_back();
        model_reset();
        for (int i = 0; i < 64; i++)
            beat((i == 0) ? 500 : (i == 63) ? -99 : -5 * i, 1'b1, 0);
        for (int i = 0; i < 64; i++) begin
            if (i == 0) beat(1000, 1'b0, 1);
            else        beat((i == 1) ? 1000 : 7 * i, 1'b1, 3);
        end
        drain();
        checks++;
        if (obs.size() != 128) begin
            errors++; $display("FAIL b2b_count: got %0d expected 128", obs.size());
            return;
        end
        checks++; if (obs[0].data != 29) begin errors++; $display("FAIL chroma_idx0: got %0d expected 29", obs[0].data); end
        checks++; if (obs[63].data != -1) begin errors++; $display("FAIL chroma_idx63: got %0d expected -1", obs[63].data); end
        checks++; if (obs[63].last !== 1'b1) begin errors++; $display("FAIL chroma_last: got %b expected 1", obs[63].last); end
        checks++; if (obs[64].data != 31 || obs[64].index != 0) begin errors++; $display("FAIL latch_idx0: got %0d@%0d expected 31@0", obs[64].data, obs[64].index); end
        checks++; if (obs[65].data != 45) begin errors++; $display("FAIL latch_idx1: got %0d expected 45", obs[65].data); end
    endtask

    task automatic test_backpressure();
        int n, d;
        model_reset();
        stall_seen = 0; stall_viol = 0;
        n = 0;
        while (acc_cyc.size() < 128 && n < 4000) begin
            d = int'($urandom_range(0, 2047)) - 1024;
            bus.s_valid = ($urandom_range(0, 9) < 7);
            bus.s_data  = d[DATA_W-1:0];
            bus.tbl_sel = $urandom_range(0, 1);
            bus.qshift  = 2'($urandom_range(0, 3));
            bus.m_ready = $urandom_range(0, 1);
            if (acc_cyc.size() == 127) bus.s_valid = bus.s_valid;
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
        n = 0;
        while (obs.size() < acc_cyc.size() && n < 200) begin
            bus.m_ready = $urandom_range(0, 1);
            tick();
            n++;
        end
        bus.m_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (obs.size() != 128 || exp_q.size() != 128) begin
            errors++; $display("FAIL bp_count: got %0d outputs expected 128", obs.size());
        end
        for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs[i].data != exp_q[i] || obs[i].index != i % 64 || obs[i].last !== (i % 64 == 63)) begin
                errors++;
                $display("FAIL bp_beat%0d: got %0d@%0d last=%b expected %0d@%0d", i,
                         obs[i].data, obs[i].index, obs[i].last, exp_q[i], i % 64);
            end
        end
        checks++; if (stall_seen == 0) begin errors++; $display("FAIL bp_stalls: got 0 stall cycles expected some"); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d changes during stall expected 0", stall_viol); end
    endtask

    task automatic test_reset_flush();
        model_reset();
        for (int i = 0; i < 20; i++) beat(40 * i, 1'b1, 0);
        drain();
        for (int i = 20; i < 30; i++) beat(40 * i, 1'b1, 0);
        bus.s_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_async: got %b expected 0", bus.m_valid); end
        @(posedge clk); #1;
        checks++; if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL flush_next: got %b expected 0", bus.m_valid); end
        rst = 1'b0;
        model_reset();
        beat(1000, 1'b0, 2);
        beat(1000, 1'b1, 0);
        drain();
        checks++;
        if (obs.size() != 2) begin
            errors++; $display("FAIL flush_count: got %0d expected 2", obs.size());
            return;
        end
        checks++; if (obs[0].index != 0 || obs[0].data != (RND ? 16 : 15)) begin errors++; $display("FAIL flush_idx0: got %0d@%0d expected %0d@0", obs[0].data, obs[0].index, RND ? 16 : 15); end
        checks++; if (obs[1].data != (RND ? 23 : 22)) begin errors++; $display("FAIL flush_idx1: got %0d expected %0d", obs[1].data, RND ? 23 : 22); end
    endtask

    initial begin
        rst         = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.tbl_sel = 1'b0;
        bus.qshift  = 2'd0;
        bus.m_ready = 1'b1;
        test_reset();
        test_luma_block();
        test_negative_and_saturation();
        test_back_to_back();
        test_backpressure();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
